freq_meter_core: RTL and testbench

FREQ_METER_CORE -- requirements
Module: freq_meter_core

---
 rtl/freq_meter_pkg.sv | 48 ++++
 rtl/seg7_dec.sv | 27 ++
 rtl/freq_meter_core.sv | 183 ++++++++++++++++++
 tb/tb_freq_meter_core.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter: control FSM states,
// BCD digit type, 7-segment patterns and the BCD increment helper.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        COUNT = 2'd1,
        LOCK  = 2'd2
    } meter_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Segment patterns, bit0 = a through bit6 = g, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Adds one to a four-digit packed BCD value; each digit rolls 9->0 and
    // carries into the next, so 9999 wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// One-digit BCD to 7-segment decoder; non-decimal codes blank the digit.
module seg7_dec
    import freq_meter_pkg::*;
(
    input  bcd_digit_t  digit,
    output logic [6:0]  seg
);

    // Pure lookup from digit value to segment pattern
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/freq_meter_core.sv
// Frequency meter core: synchronises signal_in, counts its rising edges in
// BCD over one gate of CTRL_DIV sysclk cycles, and latches the result onto
// four 7-segment outputs. A measurement cycle is CLEAR -> COUNT -> LOCK.
// Optional build macro FREQ_OVF_EN: adds the ovf output and makes the
// counter saturate at 9999 instead of wrapping.
module freq_meter_core
    import freq_meter_pkg::*;
#(
    parameter int CTRL_DIV = 50000000
)
(
    input  logic       sysclk,
    input  logic       rst,
    input  logic       signal_in,
    output logic [6:0] freqout3,
    output logic [6:0] freqout2,
    output logic [6:0] freqout1,
    output logic [6:0] freqout0
`ifdef FREQ_OVF_EN
    ,
    output logic       ovf
`endif
);

    localparam int               DIV_W    = $clog2(CTRL_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CTRL_DIV - 1);

    logic             sync_meta;
    logic             sync_stable;
    logic             sync_prev;
    logic             edge_pulse;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    meter_state_t     state;
    meter_state_t     state_next;
    logic             clear_en;
    logic             count_en;
    logic             lock_load;

    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [15:0]      disp_q;

`ifdef FREQ_OVF_EN
    logic             ovf_q;
    logic             ovf_d;
    logic             ovf_disp_q;
`endif

    // Two-flop synchroniser plus a registered rising-edge detector
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
            edge_pulse  <= 1'b0;
        end else begin
            sync_meta   <= signal_in;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
            edge_pulse  <= sync_stable & ~sync_prev;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Gate-length divider: counts 0..CTRL_DIV-1 and wraps on tick
    always_ff @(posedge sysclk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Control FSM state register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: the FSM only moves on a divider tick
    always_comb begin
        state_next = state;
        if (tick) begin
            case (state)
                CLEAR:   state_next = COUNT;
                COUNT:   state_next = LOCK;
                LOCK:    state_next = CLEAR;
                default: state_next = CLEAR;
            endcase
        end
    end

    // FSM outputs: clear the counter, enable counting, and load the display
    // on the last COUNT cycle
    always_comb begin
        clear_en  = 1'b0;
        count_en  = 1'b0;
        lock_load = 1'b0;
        case (state)
            CLEAR: clear_en = 1'b1;
            COUNT: begin
                count_en  = 1'b1;
                lock_load = tick;
            end
            default: ;
        endcase
    end

    // Next counter value; clear has priority over an edge in the same cycle.
    // The display loads this next value so an edge in the final gate cycle
    // is still counted, making the gate exactly CTRL_DIV cycles wide.
    always_comb begin
        cnt_d = cnt_q;
`ifdef FREQ_OVF_EN
        ovf_d = ovf_q;
`endif
        if (clear_en) begin
            cnt_d = '0;
`ifdef FREQ_OVF_EN
            ovf_d = 1'b0;
`endif
        end else if (count_en && edge_pulse) begin
`ifdef FREQ_OVF_EN
            if (cnt_q == BCD_MAX) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = bcd_inc(cnt_q);
            end
`else
            cnt_d = bcd_inc(cnt_q);
`endif
        end
    end

    // BCD counter (and overflow flag) registers
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cnt_q <= '0;
`ifdef FREQ_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            cnt_q <= cnt_d;
`ifdef FREQ_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

    // Display registers capture the result at COUNT->LOCK and hold it
    always_ff @(posedge sysclk) begin
        if (rst) begin
            disp_q <= '0;
`ifdef FREQ_OVF_EN
            ovf_disp_q <= 1'b0;
`endif
        end else if (lock_load) begin
            disp_q <= cnt_d;
`ifdef FREQ_OVF_EN
            ovf_disp_q <= ovf_d;
`endif
        end
    end

`ifdef FREQ_OVF_EN
    assign ovf = ovf_disp_q;
`endif

    seg7_dec u_dig3 (.digit(bcd_digit_t'(disp_q[15:12])), .seg(freqout3));
    seg7_dec u_dig2 (.digit(bcd_digit_t'(disp_q[11:8])),  .seg(freqout2));
    seg7_dec u_dig1 (.digit(bcd_digit_t'(disp_q[7:4])),   .seg(freqout1));
    seg7_dec u_dig0 (.digit(bcd_digit_t'(disp_q[3:0])),   .seg(freqout0));

endmodule

// File: tb/tb_freq_meter_core.sv
// Directed bench for freq_meter_core. Three instances with gate lengths of
// 100, 2000 and 20002 cycles share clock and reset; each has its own input.
module tb_freq_meter_core;

    localparam logic [6:0]  SEG_ZERO  = 7'h3F;
    localparam logic [6:0]  SEG_ONE   = 7'h06;
    localparam logic [6:0]  SEG_NINE  = 7'h6F;
    localparam logic [27:0] DISP_0000 = {SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO};
    localparam logic [27:0] DISP_0010 = {SEG_ZERO, SEG_ZERO, SEG_ONE,  SEG_ZERO};
    localparam logic [27:0] DISP_1000 = {SEG_ONE,  SEG_ZERO, SEG_ZERO, SEG_ZERO};
    localparam logic [27:0] DISP_0001 = {SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ONE};
    localparam logic [27:0] DISP_9999 = {SEG_NINE, SEG_NINE, SEG_NINE, SEG_NINE};

    logic sysclk = 1'b0;
    logic rst    = 1'b1;
    logic sig_a;
    logic sig_b;
    logic sig_c;
    int   mode_a = 0;

    logic [6:0] a3, a2, a1, a0;
    logic [6:0] b3, b2, b1, b0;
    logic [6:0] c3, c2, c1, c0;
`ifdef FREQ_OVF_EN
    logic ovf_a, ovf_b, ovf_c;
`endif

    int check_cnt = 0;
    int fail_cnt  = 0;

    always #5 sysclk = ~sysclk;

    freq_meter_core #(.CTRL_DIV(100)) dut_a (
        .sysclk(sysclk), .rst(rst), .signal_in(sig_a),
        .freqout3(a3), .freqout2(a2), .freqout1(a1), .freqout0(a0)
`ifdef FREQ_OVF_EN
        , .ovf(ovf_a)
`endif
    );

    freq_meter_core #(.CTRL_DIV(2000)) dut_b (
        .sysclk(sysclk), .rst(rst), .signal_in(sig_b),
        .freqout3(b3), .freqout2(b2), .freqout1(b1), .freqout0(b0)
`ifdef FREQ_OVF_EN
        , .ovf(ovf_b)
`endif
    );

    freq_meter_core #(.CTRL_DIV(20002)) dut_c (
        .sysclk(sysclk), .rst(rst), .signal_in(sig_c),
        .freqout3(c3), .freqout2(c2), .freqout1(c1), .freqout0(c0)
`ifdef FREQ_OVF_EN
        , .ovf(ovf_c)
`endif
    );

    // Input for instance A: period-10 square wave (mode 0) or held high (mode 1)
    initial begin
        int phase;
        phase = 0;
        sig_a = 1'b0;
        forever begin
            @(negedge sysclk);
            if (mode_a == 1) begin
                sig_a = 1'b1;
            end else begin
                phase++;
                if (phase == 5) begin
                    phase = 0;
                    sig_a = ~sig_a;
                end
            end
        end
    end

    // Inputs for instances B and C: period-2 square wave
    initial begin
        sig_b = 1'b0;
        sig_c = 1'b0;
        forever begin
            @(negedge sysclk);
            sig_b = ~sig_b;
            sig_c = ~sig_c;
        end
    end

    task automatic check_output(input string tag, input logic [27:0] observed,
                                input logic [27:0] expected);
        check_cnt++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Wait a number of rising edges, then settle on the following falling edge
    task automatic apply_stimulus(input int edges);
        repeat (edges) @(posedge sysclk);
        @(negedge sysclk);
    endtask

    initial begin
        $display("[TB] freq_meter_core directed test start");

        // Reset held for 5 cycles: every digit shows 0
        rst = 1'b1;
        apply_stimulus(5);
        check_output("reset_a", {a3, a2, a1, a0}, DISP_0000);
        check_output("reset_b", {b3, b2, b1, b0}, DISP_0000);
        check_output("reset_c", {c3, c2, c1, c0}, DISP_0000);
`ifdef FREQ_OVF_EN
        check_output("reset_ovf_a", {27'd0, ovf_a}, 28'd0);
        check_output("reset_ovf_b", {27'd0, ovf_b}, 28'd0);
        check_output("reset_ovf_c", {27'd0, ovf_c}, 28'd0);
`endif

        // Release; edge counts below are rising edges since release
        rst = 1'b0;

        // A: gate is edges 100..199, 10 pulses -> 0010
        apply_stimulus(250);
        check_output("count_a_first", {a3, a2, a1, a0}, DISP_0010);

        // A: second measurement loaded at edge 499
        apply_stimulus(300);
        check_output("count_a_second", {a3, a2, a1, a0}, DISP_0010);

        // B: gate edges 2000..3999, 1000 pulses -> carry into thousands
        apply_stimulus(3950);
        check_output("carry_b", {b3, b2, b1, b0}, DISP_1000);
`ifdef FREQ_OVF_EN
        check_output("carry_ovf_b", {27'd0, ovf_b}, 28'd0);
`endif
        // C has not finished its first gate yet: display holds 0000
        check_output("hold_c", {c3, c2, c1, c0}, DISP_0000);

        // C: gate edges 20002..40003, 10001 pulses
        apply_stimulus(35600);
`ifdef FREQ_OVF_EN
        check_output("ovf_c_display", {c3, c2, c1, c0}, DISP_9999);
        check_output("ovf_c_flag", {27'd0, ovf_c}, 28'd1);
`else
        check_output("wrap_c", {c3, c2, c1, c0}, DISP_0001);
`endif

        // Idle: A input held high across reset; its only rise lands in CLEAR
        rst    = 1'b1;
        mode_a = 1;
        apply_stimulus(5);
        check_output("reset2_a", {a3, a2, a1, a0}, DISP_0000);
        rst = 1'b0;
        apply_stimulus(250);
        check_output("idle_a_first", {a3, a2, a1, a0}, DISP_0000);
        apply_stimulus(300);
        check_output("idle_a_second", {a3, a2, a1, a0}, DISP_0000);

        // Mid-gate reset: restart A with the square wave
        rst    = 1'b1;
        mode_a = 0;
        apply_stimulus(3);
        rst = 1'b0;
        apply_stimulus(450);
        check_output("pre_reset_a", {a3, a2, a1, a0}, DISP_0010);
        rst = 1'b1;
        apply_stimulus(2);
        check_output("midgate_reset_a", {a3, a2, a1, a0}, DISP_0000);
        rst = 1'b0;
        apply_stimulus(250);
        check_output("after_reset_a", {a3, a2, a1, a0}, DISP_0010);

        $display("%0d/%0d checks passed", check_cnt - fail_cnt, check_cnt);
        $finish;
    end

endmodule
